// File: rtl/m2_pkg.sv
// m2_pkg: shared states, plane encoding and frame geometry for the IDCT block mover.
package m2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_FETCH_DRAIN,
      S_IDCT_START,
      S_WAIT_IDCT,
      S_WRITE,
      S_WRITE_DRAIN,
      S_NEXT
   } m2_block_mover_state_type;

   typedef enum logic [1:0] {PLANE_Y, PLANE_U, PLANE_V} m2_plane_type;

   localparam logic [17:0] PRE_IDCT_BASE = 18'd76800;
   localparam logic [17:0] U_COEF_OFS    = 18'd76800;
   localparam logic [17:0] V_COEF_OFS    = 18'd115200;
   localparam logic [17:0] Y_BASE        = 18'd0;
   localparam logic [17:0] U_BASE        = 18'd38400;
   localparam logic [17:0] V_BASE        = 18'd57600;
   localparam logic [17:0] Y_WIDTH       = 18'd320;
   localparam logic [17:0] UV_WIDTH      = 18'd160;
   localparam int unsigned BLOCK_ROWS    = 30;
   localparam logic [5:0]  Y_BLOCK_COLS  = 6'd40;
   localparam logic [5:0]  UV_BLOCK_COLS = 6'd20;

   function automatic logic [17:0] coef_base(m2_plane_type p);
      return p == PLANE_Y ? PRE_IDCT_BASE : p == PLANE_U ? PRE_IDCT_BASE + U_COEF_OFS : PRE_IDCT_BASE + V_COEF_OFS;
   endfunction

   function automatic logic [17:0] out_base(m2_plane_type p);
      return p == PLANE_Y ? Y_BASE : p == PLANE_U ? U_BASE : V_BASE;
   endfunction

   function automatic logic [17:0] plane_width(m2_plane_type p);
      return p == PLANE_Y ? Y_WIDTH : UV_WIDTH;
   endfunction

   function automatic logic [5:0] plane_cols(m2_plane_type p);
      return p == PLANE_Y ? Y_BLOCK_COLS : UV_BLOCK_COLS;
   endfunction

endpackage

// File: rtl/m2_addr_gen.sv
// m2_addr_gen: block position counters and shift/add address generation for fetch and write-back.
module m2_addr_gen
   import m2_pkg::*;
#(
   parameter int unsigned ROWS = BLOCK_ROWS
) (
   input  logic        Clock_i,
   input  logic        Reset_i,
   input  logic        step_col_i,
   input  logic        step_row_i,
   input  logic        rewind_i,
   input  logic        next_block_i,
   output logic [17:0] fetch_addr_o,
   output logic [17:0] write_addr_o,
   output logic        last_block_o
);

   m2_plane_type plane_q, plane_d;
   logic [4:0]   brow_q, brow_d;
   logic [5:0]   bcol_q, bcol_d;
   logic [2:0]   col_q, col_d;
   logic [17:0]  brow_base_q, brow_base_d, rs_q, rs_d, w;
   logic         last_col, last_row;

   always_ff @(posedge Clock_i or posedge Reset_i) begin
      if (Reset_i) begin
         plane_q     <= PLANE_Y;
         brow_q      <= '0;
         bcol_q      <= '0;
         col_q       <= '0;
         brow_base_q <= '0;
         rs_q        <= '0;
      end else begin
         plane_q     <= plane_d;
         brow_q      <= brow_d;
         bcol_q      <= bcol_d;
         col_q       <= col_d;
         brow_base_q <= brow_base_d;
         rs_q        <= rs_d;
      end
   end

   // brow_base is the block-row origin in coefficient units; halving it gives the output-word origin
   always_comb begin
      w           = plane_width(plane_q);
      last_col    = bcol_q == plane_cols(plane_q) - 6'd1;
      last_row    = brow_q == 5'(ROWS - 1);
      plane_d     = plane_q;
      brow_d      = brow_q;
      bcol_d      = bcol_q;
      brow_base_d = brow_base_q;
      rs_d        = rs_q;
      col_d       = col_q;
      if (next_block_i) begin
         rs_d   = '0;
         col_d  = '0;
         bcol_d = last_col ? '0 : bcol_q + 6'd1;
         if (last_col) begin
            brow_d      = last_row ? '0 : brow_q + 5'd1;
            brow_base_d = last_row ? '0 : brow_base_q + (w << 3);
            if (last_row) plane_d = plane_q == PLANE_Y ? PLANE_U : plane_q == PLANE_U ? PLANE_V : PLANE_Y;
         end
      end else if (rewind_i) begin
         rs_d  = '0;
         col_d = '0;
      end else if (step_row_i) begin
         rs_d  = rs_q + w;
         col_d = '0;
      end else if (step_col_i) begin
         col_d = col_q + 3'd1;
      end
   end

   assign last_block_o = plane_q == PLANE_V && last_row && last_col;
   assign fetch_addr_o = coef_base(plane_q) + brow_base_q + {9'd0, bcol_q, 3'd0} + rs_q + {15'd0, col_q};
   assign write_addr_o = out_base(plane_q) + {1'b0, brow_base_q[17:1]} + {10'd0, bcol_q, 2'd0}
                       + {1'b0, rs_q[17:1]} + {15'd0, col_q};

endmodule

// File: rtl/m2_block_mover.sv
// m2_block_mover: walks Y/U/V 8x8 blocks, fetching coefficients for the IDCT core and
// writing the packed sample words back to SRAM.
module m2_block_mover
   import m2_pkg::*;
#(
   parameter int unsigned ROWS = BLOCK_ROWS
) (
   input  logic        Clock_i,
   input  logic        Reset_i,
   input  logic        Enable_i,
   output logic        Busy_o,
   output logic        Done_o,
   output logic [17:0] SRAM_address_o,
   input  logic [15:0] SRAM_read_data_i,
   output logic [15:0] SRAM_write_data_o,
   output logic        SRAM_we_n_o,
   output logic [5:0]  C_wr_address_o,
   output logic [15:0] C_wr_data_o,
   output logic        C_wr_en_o,
   output logic        Idct_start_o,
   input  logic        Idct_done_i,
   output logic [4:0]  S_rd_address_o,
   input  logic [15:0] S_rd_data_i
);

   m2_block_mover_state_type state_q, state_d;
   logic [5:0]  cnt_q, cnt_d, a1_q, a2_q;
   logic        v1_q, v2_q, wv_q;
   logic [1:0]  wi_q;
   logic        fetch, step_row, step_col, last_block;
   logic [17:0] fetch_addr, write_addr;

   m2_addr_gen #(.ROWS(ROWS)) u_addr_gen (
      .Clock_i      (Clock_i),
      .Reset_i      (Reset_i),
      .step_col_i   (step_col),
      .step_row_i   (step_row),
      .rewind_i     (state_q == S_IDCT_START),
      .next_block_i (state_q == S_NEXT),
      .fetch_addr_o (fetch_addr),
      .write_addr_o (write_addr),
      .last_block_o (last_block)
   );

   // v1/v2 and a1/a2 carry each read index across the two-cycle SRAM latency;
   // wv/wi carry each sample index across the one-cycle sample buffer latency
   always_ff @(posedge Clock_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         a1_q    <= '0;
         a2_q    <= '0;
         wv_q    <= 1'b0;
         wi_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         v1_q    <= state_q == S_FETCH;
         v2_q    <= v1_q;
         a1_q    <= cnt_q;
         a2_q    <= a1_q;
         wv_q    <= state_q == S_WRITE;
         wi_q    <= cnt_q[1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         S_IDLE:        if (Enable_i) state_d = S_FETCH;
         S_FETCH: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) state_d = S_FETCH_DRAIN;
         end
         S_FETCH_DRAIN: begin
            cnt_d = cnt_q == 6'd1 ? 6'd0 : cnt_q + 6'd1;
            if (cnt_q == 6'd1) state_d = S_IDCT_START;
         end
         S_IDCT_START:  state_d = S_WAIT_IDCT;
         S_WAIT_IDCT:   if (Idct_done_i) state_d = S_WRITE;
         S_WRITE: begin
            cnt_d = cnt_q == 6'd31 ? 6'd0 : cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = S_WRITE_DRAIN;
         end
         S_WRITE_DRAIN: state_d = S_NEXT;
         S_NEXT:        state_d = last_block ? S_IDLE : S_FETCH;
         default:       state_d = S_IDLE;
      endcase
   end

   assign fetch    = state_q == S_FETCH;
   assign step_row = fetch ? cnt_q[2:0] == 3'd7 : wv_q && wi_q == 2'd3;
   assign step_col = (fetch || wv_q) && !step_row;

   assign Busy_o            = state_q != S_IDLE;
   assign Done_o            = state_q == S_NEXT && last_block;
   assign SRAM_address_o    = fetch ? fetch_addr : wv_q ? write_addr : '0;
   assign SRAM_we_n_o       = !wv_q;
   assign SRAM_write_data_o = wv_q ? S_rd_data_i : '0;
   assign C_wr_en_o         = v2_q;
   assign C_wr_address_o    = v2_q ? a2_q : '0;
   assign C_wr_data_o       = v2_q ? SRAM_read_data_i : '0;
   assign Idct_start_o      = state_q == S_IDCT_START;
   assign S_rd_address_o    = state_q == S_WRITE ? cnt_q[4:0] : '0;

endmodule
